fpadd_result_queue: RTL and testbench
=====================================

Name: fpadd_result_queue

Overview:
Registered result/writeback stage directly downstream of the combinational FP adder. Captures each valid adder result with its destination tag and the per-operation exception flags into a small in-order FIFO. Presents results to the FP register-file writeback port over a valid/ready handshake. Accumulates retired exception flags into sticky fflags for the CSR block.

Parameters:
EXPONENT_WIDTH, 8, exponent bits of the FP format (matches the adder)
MANTISSA_WIDTH, 23, mantissa bits of the FP format (matches the adder)
TAG_WIDTH, 6, destination-register/ROB tag width
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk_in  input  1  clock
rst_N_in  input  1  reset; one clock; reset is asynchronous and active-low
res_valid_in  input  1  adder result valid (driven from adder valid_out)
res_ready_out  output  1  queue can accept a result this cycle
res_in  input  EXPONENT_WIDTH+MANTISSA_WIDTH+1  adder result word
tag_in  input  TAG_WIDTH  tag travelling with the operation
underflow_in  input  1  adder underflow flag
overflow_in  input  1  adder overflow flag
invalid_in  input  1  adder invalid-operation flag
wb_valid_out  output  1  head entry valid
wb_ready_in  input  1  writeback port accepts head
wb_data_out  output  EXPONENT_WIDTH+MANTISSA_WIDTH+1  head result word
wb_tag_out  output  TAG_WIDTH  head tag
wb_flags_out  output  3  head flags {NV,OF,UF}
fflags_out  output  3  sticky retired flags {NV,OF,UF}
fflags_clear_in  input  1  synchronous clear of sticky flags
flush_in  input  1  synchronous pipeline flush (mispredict/exception)
count_out  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- State: DEPTH-entry storage of {data, tag, flags}; rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0; count register, 0..DEPTH.
- Reset (async, rst_N_in=0): ptrs=0, count=0, fflags=0. Resulting outputs: wb_valid_out=0, res_ready_out=1, count_out=0, fflags_out=0. wb_data_out/wb_tag_out/wb_flags_out = 0; storage cleared.
- res_ready_out = (count != DEPTH). Depends on registered count only; no combinational path from wb_ready_in or res_valid_in.
- push = res_valid_in && res_ready_out && !flush_in. Writes entry at wr_ptr and advances wr_ptr.
- pop = wb_valid_out && wb_ready_in && !flush_in. Advances rd_ptr.
- wb_valid_out = (count != 0). wb_* outputs are driven from the entry at rd_ptr.
- Latency: result pushed in cycle N appears on wb_* in cycle N+1. No same-cycle bypass, including when empty.
- Order: strict FIFO. wb_* remain stable while wb_valid_out && !wb_ready_in.
- count update: push&&!pop -> +1; pop&&!push -> -1; both -> unchanged.
- Full: res_ready_out=0 even if a pop occurs that cycle. Upstream must hold its result; an offered result is not accepted.
- Empty: pop impossible; wb_ready_in is ignored.
- Sticky flags: on pop, fflags <= (fflags_clear_in ? 0 : fflags) | wb_flags_out.
  - If clear and pop happen in the same cycle, the popped flags survive.
  - Clear without pop -> 0. Flags are never set by push, only on retirement.
- flush_in: next cycle ptrs=0, count=0, wb_valid_out=0. Any same-cycle push and pop are discarded. fflags are unaffected; fflags_clear_in still applies.
- Reset mid-operation: all entries discarded immediately (async); no output glitch is required after rst_N_in deasserts.
- Data is stored verbatim; the block performs no rounding or NaN canonicalization.

Test Plan:
- Reset, then push res_in=32'h3F800000, tag 5, flags 0, wb_ready_in=1 -> cycle+1: wb_valid_out=1, wb_data_out=3F800000, wb_tag_out=5; cycle+2: wb_valid_out=0, count_out=0.
- wb_ready_in=0; push tags 1,2,3,4 -> count_out=4, res_ready_out=0; 5th offer (tag 9) not accepted. Raise wb_ready_in -> tags drain 1,2,3,4 on consecutive cycles; tag 9 accepted the cycle after count drops to 3.
- count=2, simultaneous push and pop -> count_out stays 2; pointers wrap correctly across 8 consecutive simultaneous push/pop cycles with no data loss.
- Pop an entry with flags NV=1 -> fflags_out=3'b100 next cycle. Then pop an OF entry with fflags_clear_in=1 the same cycle -> fflags_out=3'b010.
- Queue holds 3 entries; assert flush_in together with res_valid_in -> next cycle count_out=0, wb_valid_out=0, res_ready_out=1; fflags_out unchanged.
- Assert rst_N_in=0 mid-drain with 2 entries -> outputs go to reset values immediately, without waiting for a clock edge; after release, the first push behaves as in scenario 1.

Source files
------------

// File: rtl/fpadd_result_queue.sv
// Writeback queue behind the FP adder: in-order FIFO of {result, tag, flags}
// with a valid/ready drain port and sticky retired exception flags.
module fpadd_result_queue #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int TAG_WIDTH      = 6,
    parameter int DEPTH          = 4
) (
    input  logic                                     clk_in,
    input  logic                                     rst_N_in,
    input  logic                                     res_valid_in,
    output logic                                     res_ready_out,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   res_in,
    input  logic [TAG_WIDTH-1:0]                     tag_in,
    input  logic                                     underflow_in,
    input  logic                                     overflow_in,
    input  logic                                     invalid_in,
    output logic                                     wb_valid_out,
    input  logic                                     wb_ready_in,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   wb_data_out,
    output logic [TAG_WIDTH-1:0]                     wb_tag_out,
    output logic [2:0]                               wb_flags_out,
    output logic [2:0]                               fflags_out,
    input  logic                                     fflags_clear_in,
    input  logic                                     flush_in,
    output logic [$clog2(DEPTH):0]                   count_out
);

    localparam int DW = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DW-1:0]        r_data  [DEPTH];
    logic [TAG_WIDTH-1:0] r_tag   [DEPTH];
    logic [2:0]           r_flags [DEPTH];
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_wr_ptr;
    logic [CW-1:0]        r_count;
    logic [2:0]           r_fflags;

    logic                 w_push;
    logic                 w_pop;
    logic [2:0]           w_in_flags;

    // Ready looks only at registered occupancy, so a full queue refuses a
    // result even when the head is retiring in the same cycle.
    assign res_ready_out = (r_count != FULL_COUNT);
    assign wb_valid_out  = (r_count != '0);
    assign w_push        = res_valid_in && res_ready_out && !flush_in;
    assign w_pop         = wb_valid_out && wb_ready_in && !flush_in;
    assign w_in_flags    = {invalid_in, overflow_in, underflow_in};

    assign wb_data_out   = r_data[r_rd_ptr];
    assign wb_tag_out    = r_tag[r_rd_ptr];
    assign wb_flags_out  = r_flags[r_rd_ptr];
    assign fflags_out    = r_fflags;
    assign count_out     = r_count;

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i]  <= '0;
                r_tag[i]   <= '0;
                r_flags[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_in) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr]  <= res_in;
                r_tag[r_wr_ptr]   <= tag_in;
                r_flags[r_wr_ptr] <= w_in_flags;
                r_wr_ptr          <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Flags become sticky only on retirement; a same-cycle clear loses to
    // the flags of the entry being retired.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            r_fflags <= '0;
        end else if (w_pop) begin
            r_fflags <= (fflags_clear_in ? 3'b000 : r_fflags) | wb_flags_out;
        end else if (fflags_clear_in) begin
            r_fflags <= '0;
        end
    end

endmodule

// File: tb/tb_fpadd_result_queue.sv
// Bench for fpadd_result_queue: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_fpadd_result_queue;

    localparam int TW = 6;
    localparam int D  = 4;
    localparam int DW = 32;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    logic          uf, of, nv;
    logic          wb_valid;
    logic          wb_ready;
    logic [DW-1:0] wb_data;
    logic [TW-1:0] wb_tag;
    logic [2:0]    wb_flags;
    logic [2:0]    fflags;
    logic          fclr;
    logic          flush;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_errors = 0;

    fpadd_result_queue #(
        .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .TAG_WIDTH(TW), .DEPTH(D)
    ) dut (
        .clk_in(clk), .rst_N_in(rst_n),
        .res_valid_in(res_valid), .res_ready_out(res_ready),
        .res_in(res), .tag_in(tag),
        .underflow_in(uf), .overflow_in(of), .invalid_in(nv),
        .wb_valid_out(wb_valid), .wb_ready_in(wb_ready),
        .wb_data_out(wb_data), .wb_tag_out(wb_tag), .wb_flags_out(wb_flags),
        .fflags_out(fflags), .fflags_clear_in(fclr),
        .flush_in(flush), .count_out(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic          r;
        logic [TW-1:0] t;
        int            exp_cnt;
        logic          exp_v;
        logic [TW-1:0] exp_t;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        logic [2:0]    f;
    } ent_t;

    vec_t tbl[12];
    ent_t mq[$];
    logic [2:0] mf;

    function automatic logic [DW-1:0] pat(input logic [TW-1:0] t);
        return 32'hA500_0000 | {26'd0, t};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [TW-1:0] t,
                         input logic [2:0] f, input logic r, input logic c, input logic fl);
        res_valid = v; res = d; tag = t;
        nv = f[2]; of = f[1]; uf = f[0];
        wb_ready = r; fclr = c; flush = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tagname);
        chk({tagname, " wb_valid"}, 64'(wb_valid), 64'd0);
        chk({tagname, " res_ready"}, 64'(res_ready), 64'd1);
        chk({tagname, " count"}, 64'(count), 64'd0);
        chk({tagname, " fflags"}, 64'(fflags), 64'd0);
        chk({tagname, " wb_data"}, 64'(wb_data), 64'd0);
        chk({tagname, " wb_tag"}, 64'(wb_tag), 64'd0);
        chk({tagname, " wb_flags"}, 64'(wb_flags), 64'd0);
    endtask

    task automatic scenario_single;
        drive(1'b1, 32'h3F80_0000, 6'd5, 3'b000, 1'b1, 1'b0, 1'b0);
        tick;
        chk("s1 wb_valid", 64'(wb_valid), 64'd1);
        chk("s1 wb_data", 64'(wb_data), 64'h3F80_0000);
        chk("s1 wb_tag", 64'(wb_tag), 64'd5);
        drive(1'b0, '0, '0, 3'b000, 1'b1, 1'b0, 1'b0);
        tick;
        chk("s1 drained valid", 64'(wb_valid), 64'd0);
        chk("s1 drained count", 64'(count), 64'd0);
    endtask

    initial begin
        // table: fill then 8 concurrent push/pop cycles (pointer wrap), drain
        tbl[0] = '{1'b1, 1'b0, 6'd10, 1, 1'b1, 6'd10};
        tbl[1] = '{1'b1, 1'b0, 6'd11, 2, 1'b1, 6'd10};
        for (int k = 0; k < 8; k++)
            tbl[2+k] = '{1'b1, 1'b1, TW'(20 + k), 2, 1'b1, (k == 0) ? 6'd11 : TW'(19 + k)};
        tbl[10] = '{1'b0, 1'b1, 6'd0, 1, 1'b1, 6'd27};
        tbl[11] = '{1'b0, 1'b1, 6'd0, 0, 1'b0, 6'd0};

        rst_n = 1'b0;
        drive(1'b0, '0, '0, 3'b000, 1'b0, 1'b0, 1'b0);
        #2;
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        scenario_single;

        // fill to full while stalled, refused fifth offer, then drain
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, pat(TW'(i)), TW'(i), 3'b000, 1'b0, 1'b0, 1'b0);
            tick;
        end
        chk("full count", 64'(count), 64'd4);
        chk("full ready", 64'(res_ready), 64'd0);
        drive(1'b1, pat(6'd9), 6'd9, 3'b000, 1'b0, 1'b0, 1'b0);
        tick;
        chk("full refuse count", 64'(count), 64'd4);
        chk("stall head tag", 64'(wb_tag), 64'd1);
        chk("stall head data", 64'(wb_data), 64'(pat(6'd1)));
        drive(1'b1, pat(6'd9), 6'd9, 3'b000, 1'b1, 1'b0, 1'b0);
        tick;
        chk("drain A tag", 64'(wb_tag), 64'd2);
        chk("drain A count", 64'(count), 64'd3);
        chk("drain A ready", 64'(res_ready), 64'd1);
        tick;
        chk("drain B tag", 64'(wb_tag), 64'd3);
        chk("drain B count", 64'(count), 64'd3);
        drive(1'b0, '0, '0, 3'b000, 1'b1, 1'b0, 1'b0);
        tick;
        chk("drain C tag", 64'(wb_tag), 64'd4);
        tick;
        chk("drain D tag", 64'(wb_tag), 64'd9);
        chk("drain D data", 64'(wb_data), 64'(pat(6'd9)));
        tick;
        chk("drain empty", 64'(wb_valid), 64'd0);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, pat(tbl[i].t), tbl[i].t, 3'b000, tbl[i].r, 1'b0, 1'b0);
            tick;
            chk($sformatf("tbl[%0d] count", i), 64'(count), 64'(tbl[i].exp_cnt));
            chk($sformatf("tbl[%0d] valid", i), 64'(wb_valid), 64'(tbl[i].exp_v));
            if (tbl[i].exp_v) begin
                chk($sformatf("tbl[%0d] tag", i), 64'(wb_tag), 64'(tbl[i].exp_t));
                chk($sformatf("tbl[%0d] data", i), 64'(wb_data), 64'(pat(tbl[i].exp_t)));
            end
        end

        // sticky flags
        drive(1'b1, 32'h7FC0_0000, 6'd1, 3'b100, 1'b0, 1'b0, 1'b0);
        tick;
        chk("nv push no sticky", 64'(fflags), 64'd0);
        chk("nv head flags", 64'(wb_flags), 64'h4);
        drive(1'b0, '0, '0, 3'b000, 1'b1, 1'b0, 1'b0);
        tick;
        chk("nv retired", 64'(fflags), 64'h4);
        drive(1'b1, 32'h7F80_0000, 6'd2, 3'b010, 1'b0, 1'b0, 1'b0);
        tick;
        drive(1'b0, '0, '0, 3'b000, 1'b1, 1'b1, 1'b0);
        tick;
        chk("of retire with clear", 64'(fflags), 64'h2);
        drive(1'b0, '0, '0, 3'b000, 1'b0, 1'b1, 1'b0);
        tick;
        chk("clear without pop", 64'(fflags), 64'h0);

        // flush with three entries and a concurrent offer
        drive(1'b1, 32'h0000_0001, 6'd3, 3'b001, 1'b1, 1'b0, 1'b0);
        tick;
        drive(1'b0, '0, '0, 3'b000, 1'b1, 1'b0, 1'b0);
        tick;
        chk("uf retired", 64'(fflags), 64'h1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pat(TW'(40 + i)), TW'(40 + i), 3'b100, 1'b0, 1'b0, 1'b0);
            tick;
        end
        chk("pre-flush count", 64'(count), 64'd3);
        drive(1'b1, pat(6'd50), 6'd50, 3'b010, 1'b1, 1'b0, 1'b1);
        tick;
        chk("flush count", 64'(count), 64'd0);
        chk("flush valid", 64'(wb_valid), 64'd0);
        chk("flush ready", 64'(res_ready), 64'd1);
        chk("flush fflags kept", 64'(fflags), 64'h1);
        drive(1'b1, pat(6'd7), 6'd7, 3'b000, 1'b0, 1'b0, 1'b0);
        tick;
        chk("post-flush tag", 64'(wb_tag), 64'd7);
        chk("post-flush count", 64'(count), 64'd1);
        drive(1'b0, '0, '0, 3'b000, 1'b1, 1'b0, 1'b0);
        tick;

        // async reset mid-drain
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pat(TW'(60 + i)), TW'(60 + i), 3'b010, 1'b0, 1'b0, 1'b0);
            tick;
        end
        drive(1'b0, '0, '0, 3'b000, 1'b1, 1'b0, 1'b0);
        tick;
        chk("pre-reset count", 64'(count), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        scenario_single;

        // randomized run against reference queue
        mq.delete();
        mf = 3'b000;
        for (int i = 0; i < 600; i++) begin
            logic v, r, c, fl, m_push, m_pop;
            ent_t e;
            v  = ($urandom_range(0, 9) < 7);
            r  = ($urandom_range(0, 9) < 5);
            c  = ($urandom_range(0, 19) == 0);
            fl = ($urandom_range(0, 39) == 0);
            e.d = $urandom;
            e.t = TW'($urandom);
            e.f = 3'($urandom);
            drive(v, e.d, e.t, e.f, r, c, fl);
            m_push = v && (mq.size() < D) && !fl;
            m_pop  = (mq.size() > 0) && r && !fl;
            if (fl) begin
                mq.delete();
                if (c) mf = 3'b000;
            end else begin
                if (m_pop) begin
                    mf = (c ? 3'b000 : mf) | mq[0].f;
                    void'(mq.pop_front());
                end else if (c) begin
                    mf = 3'b000;
                end
                if (m_push) mq.push_back(e);
            end
            tick;
            chk("rnd count", 64'(count), 64'(mq.size()));
            chk("rnd valid", 64'(wb_valid), 64'(mq.size() != 0));
            chk("rnd ready", 64'(res_ready), 64'(mq.size() < D));
            chk("rnd fflags", 64'(fflags), 64'(mf));
            if (mq.size() != 0) begin
                chk("rnd data", 64'(wb_data), 64'(mq[0].d));
                chk("rnd tag", 64'(wb_tag), 64'(mq[0].t));
                chk("rnd flags", 64'(wb_flags), 64'(mq[0].f));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
